// File: rtl/core_mem_pkg.sv
// Shared types for the core memory arbiter: FSM states, grant owner
// and the default WAIT timeout.
package core_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } gnt_e;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) round-robin arbiter onto a single memory port
// with one outstanding transaction and a WAIT timeout.
module mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic                if_err,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic                dm_done,
    output logic                dm_err,
    output logic [DATA_W-1:0]   dm_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int SW = DATA_W / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    gnt_e              last_q, last_d;
    gnt_e              pick;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              timeout;
    logic              rv_hit;
    logic [DATA_W-1:0] resp_data;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]     mem_wstrb_q, mem_wstrb_d;

    logic              if_done_q, if_done_d;
    logic              if_err_q, if_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              dm_done_q, dm_done_d;
    logic              dm_err_q, dm_err_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_done_d   = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_done_d   = 1'b0;
        dm_err_d    = 1'b0;
        dm_rdata_d  = dm_rdata_q;

        // Contention goes to whoever did not win last time
        pick = GNT_IF;
        if (if_req && dm_req) begin
            pick = (last_q == GNT_IF) ? GNT_DM : GNT_IF;
        end else if (dm_req) begin
            pick = GNT_DM;
        end

        // The mem_req cycle never accepts a completion
        rv_hit    = mem_rvalid && !mem_req_q;
        timeout   = (cnt_q == CW'(TIMEOUT - 1));
        resp_data = rv_hit ? mem_rdata : '0;

        unique case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    last_d    = pick;
                    mem_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT;
                    if (pick == GNT_DM) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_wstrb_d = dm_wstrb;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            WAIT: begin
                if (rv_hit || timeout) begin
                    state_d = RESP;
                    if (last_q == GNT_DM) begin
                        dm_done_d  = 1'b1;
                        dm_err_d   = !rv_hit;
                        dm_rdata_d = resp_data;
                    end else begin
                        if_done_d  = 1'b1;
                        if_err_d   = !rv_hit;
                        if_rdata_d = resp_data;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= GNT_DM;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_done_q   <= 1'b0;
            dm_err_q    <= 1'b0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_done_q   <= if_done_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_done_q   <= dm_done_d;
            dm_err_q    <= dm_err_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign dm_done   = dm_done_q;
    assign dm_err    = dm_err_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single-requester
// transactions plus hand sequences for arbitration, timeout and reset.
module tb_mem_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done, if_err;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_done, dm_err;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] hold_if = '0;
    logic [31:0] hold_dm = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
        .dm_done(dm_done), .dm_err(dm_err), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rd;
        int          d;
        bit          nz;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = '0;
        dm_wdata   = '0;
        dm_wstrb   = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        hold_if = '0;
        hold_dm = '0;
    endtask

    // Entered just after the edge of the IDLE cycle that sees the request
    task automatic serve(input bit dm, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int d, input logic [31:0] rd,
                         input bit err, input bit nz);
        logic [31:0] exp_rd;
        exp_rd = err ? 32'h0 : rd;
        step();
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, we);
        chk("mem_addr", mem_addr, addr);
        chk("mem_wdata", mem_wdata, wd);
        chk("mem_wstrb", mem_wstrb, ws);
        if (nz) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0BAD0;
        end
        if (err) begin
            repeat (TO - 1) begin
                step();
                mem_rvalid = 1'b0;
                chk("early_done", {if_done, dm_done}, 0);
            end
            step();
        end else begin
            repeat (d) begin
                step();
                mem_rvalid = 1'b0;
                chk("early_done", {if_done, dm_done}, 0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            step();
            mem_rvalid = 1'b0;
        end
        chk("busy_resp", busy, 1);
        if (dm) begin
            chk("dm_done", dm_done, 1);
            chk("dm_err", dm_err, err);
            chk("dm_rdata", dm_rdata, exp_rd);
            chk("if_idle_done", if_done, 0);
            chk("if_hold", if_rdata, hold_if);
            hold_dm = exp_rd;
            dm_req  = 1'b0;
        end else begin
            chk("if_done", if_done, 1);
            chk("if_err", if_err, err);
            chk("if_rdata", if_rdata, exp_rd);
            chk("dm_idle_done", dm_done, 0);
            chk("dm_hold", dm_rdata, hold_dm);
            hold_if = exp_rd;
            if_req  = 1'b0;
        end
        step();
        chk("done_pulse", {if_done, dm_done}, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        vecs[0] = '{0, 0, 32'h8000_0000, 32'h0,         4'h0, 32'h0000_0013, 1, 0};
        vecs[1] = '{1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0000_0001, 2, 1};
        vecs[2] = '{1, 0, 32'h8000_2004, 32'h0,         4'h0, 32'hCAFE_F00D, 3, 0};
        vecs[3] = '{0, 0, 32'h8000_0004, 32'hA5A5_A5A5, 4'h3, 32'h0010_0093, 5, 1};
        vecs[4] = '{1, 1, 32'h0000_0010, 32'h1234_5678, 4'h3, 32'h0,         1, 0};

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_mem", {mem_req, mem_we, mem_wstrb}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_done", {if_done, if_err, dm_done, dm_err}, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);

        foreach (vecs[i]) begin
            if (vecs[i].dm) begin
                dm_req   = 1'b1;
                dm_we    = vecs[i].we;
                dm_addr  = vecs[i].addr;
                dm_wdata = vecs[i].wdata;
                dm_wstrb = vecs[i].wstrb;
                serve(1, vecs[i].we, vecs[i].addr,
                      vecs[i].wdata, vecs[i].wstrb,
                      vecs[i].d, vecs[i].rd, 0, vecs[i].nz);
            end else begin
                if_req   = 1'b1;
                if_addr  = vecs[i].addr;
                dm_we    = 1'b1;
                dm_wdata = vecs[i].wdata;
                dm_wstrb = vecs[i].wstrb;
                serve(0, 0, vecs[i].addr, 32'h0, 4'h0,
                      vecs[i].d, vecs[i].rd, 0, vecs[i].nz);
            end
        end

        // Simultaneous requests right after reset: fetch first
        do_reset();
        if_req   = 1'b1;
        if_addr  = 32'h8000_0000;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h8000_1000;
        dm_wdata = 32'hDEAD_BEEF;
        dm_wstrb = 4'hF;
        serve(0, 0, 32'h8000_0000, 0, 0, 1, 32'h0000_0013, 0, 0);
        serve(1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 1, 32'h1, 0, 0);

        // Continuous contention alternates
        if_addr = 32'h8000_0100;
        dm_addr = 32'h8000_0200;
        dm_we   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if_req = 1'b1;
            dm_req = 1'b1;
            if (k % 2 == 1)
                serve(1, 0, 32'h8000_0200, 32'hDEAD_BEEF, 4'hF,
                      1, 32'h1000 + k, 0, 0);
            else
                serve(0, 0, 32'h8000_0100, 0, 0, 1, 32'h1000 + k, 0, 0);
        end
        if_req = 1'b0;
        step();

        // Timeout with no completion
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h8000_3000;
        dm_wdata = '0;
        dm_wstrb = '0;
        serve(1, 0, 32'h8000_3000, 0, 0, 0, 32'h0, 1, 0);

        // Completion on the timeout cycle wins
        dm_req = 1'b1;
        serve(1, 0, 32'h8000_3000, 0, 0, TO - 1, 32'h1234_5678, 0, 0);

        // Reset while a fetch is in WAIT
        if_req  = 1'b1;
        if_addr = 32'h8000_0040;
        step();
        chk("rst_wait_mreq", mem_req, 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_mem", {mem_req, mem_addr}, 0);
        chk("async_rdata", {if_rdata, dm_rdata}, 0);
        if_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0055;
        step();
        mem_rvalid = 1'b0;
        chk("drop_done", {if_done, dm_done}, 0);
        chk("drop_busy", busy, 0);
        step();
        chk("drop_done2", {if_done, dm_done}, 0);
        chk("drop_rdata", if_rdata, 0);
        hold_if = '0;
        hold_dm = '0;

        // Last grant reset to DM: contention picks fetch again
        if_req = 1'b1;
        dm_req = 1'b1;
        serve(0, 0, 32'h8000_0040, 0, 0, 2, 32'h0000_0777, 0, 0);
        serve(1, 0, 32'h8000_3000, 0, 0, 1, 32'h0000_0888, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
